// File: rtl/la_trigger_unit.sv
// -----------------------------------------------------------------------------
// la_trigger_unit
//
// Trigger stage between the user project's 24 monitored signals and the logic
// analyzer core. The user signals are sampled through a two-register pipeline
// and forwarded on la_data_o. A programmable pattern/edge trigger opens a
// capture window (la_run), which is aligned with la_data_o so the first
// la_run cycle shows the sample that caused the trigger.
//
// Build option:
//   LA_TRIG_TIMESTAMP_EN - when defined, a 32-bit saturating counter measures
//                          the number of cycles from arm to trigger and is
//                          readable at offset 0x18. When undefined, no counter
//                          is built and 0x18 reads all ones.
//
// Register map (byte offsets, decoded on address bits [11:2]):
//   0x00 trig_mask [23:0]   0x04 trig_value [23:0]   0x08 edge_mask [23:0]
//   0x0C post_count [15:0]  (0 = capture until abort)
//   0x10 ctrl  (write-only, reads 0): bit0 arm, bit1 abort (self-clearing)
//   0x14 status (read-only): {trig_seen, state[1:0]}
//   0x18 trig_ts (timestamp build only)
//   other offsets read 0xFFFFFFFF
//
// Ports:
//   axi_clk, axi_reset_n      clock, asynchronous active-low reset
//   axi_aw*/axi_w*            AXI-Lite write; awready = wready = awvalid & wvalid
//   axi_ar*/axi_r*            AXI-Lite read; arready = rvalid = arvalid,
//                             rdata is a combinational mux
//   cc_la_enable              register writes take effect only while high
//   up_la_data   [23:0]       monitored user signals
//   la_data_o    [23:0]       sampled data, two-cycle latency
//   la_run                    capture window, aligned with la_data_o
//   la_trig_done              one-cycle pulse on entry to DONE
// -----------------------------------------------------------------------------
module la_trigger_unit #(
    parameter int pDATA_WIDTH = 32,
    parameter int pADDR_WIDTH = 15
) (
    input  logic                     axi_clk,
    input  logic                     axi_reset_n,
    // AXI-Lite write
    input  logic                     axi_awvalid,
    input  logic [pADDR_WIDTH-1:0]   axi_awaddr,
    input  logic                     axi_wvalid,
    input  logic [pDATA_WIDTH-1:0]   axi_wdata,
    input  logic [3:0]               axi_wstrb,
    output logic                     axi_awready,
    output logic                     axi_wready,
    // AXI-Lite read
    input  logic                     axi_arvalid,
    input  logic [pADDR_WIDTH-1:0]   axi_araddr,
    input  logic                     axi_rready,
    output logic                     axi_arready,
    output logic                     axi_rvalid,
    output logic [pDATA_WIDTH-1:0]   axi_rdata,
    // logic analyzer side
    input  logic                     cc_la_enable,
    input  logic [23:0]              up_la_data,
    output logic [23:0]              la_data_o,
    output logic                     la_run,
    output logic                     la_trig_done
);

    localparam logic [9:0] A_MASK   = 10'h000;
    localparam logic [9:0] A_VALUE  = 10'h001;
    localparam logic [9:0] A_EDGE   = 10'h002;
    localparam logic [9:0] A_POST   = 10'h003;
    localparam logic [9:0] A_CTRL   = 10'h004;
    localparam logic [9:0] A_STATUS = 10'h005;
    localparam logic [9:0] A_TS     = 10'h006;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  state_bits;

    logic [23:0] trig_mask;
    logic [23:0] trig_value;
    logic [23:0] edge_mask;
    logic [15:0] post_count;
    logic [15:0] pc_cnt;
    logic        trig_seen;

    logic [23:0] data_p1;
    logic [23:0] data_p2;

    logic [9:0]  wr_idx;
    logic [9:0]  rd_idx;
    logic        wr_en;
    logic        arm_req;
    logic        abort_req;
    logic        arm_take;
    logic        pattern_hit;
    logic        edge_hit;
    logic        match;
    logic        trig_fire;
    logic        cap_end;

    logic [pDATA_WIDTH-1:0] rd_data;

    // Ignored inputs and undecoded address/data bits.
    logic unused_ok;
    assign unused_ok = &{1'b0, axi_wstrb, axi_rready,
                         axi_awaddr[pADDR_WIDTH-1:12], axi_awaddr[1:0],
                         axi_araddr[pADDR_WIDTH-1:12], axi_araddr[1:0],
                         axi_wdata[pDATA_WIDTH-1:24]};

    // ------------------------------------------------------------------
    // Bus handshake and write decode
    // ------------------------------------------------------------------
    assign axi_awready = axi_awvalid & axi_wvalid;
    assign axi_wready  = axi_awvalid & axi_wvalid;
    assign axi_arready = axi_arvalid;
    assign axi_rvalid  = axi_arvalid;

    assign wr_idx    = axi_awaddr[11:2];
    assign rd_idx    = axi_araddr[11:2];
    assign wr_en     = cc_la_enable & axi_awvalid & axi_wvalid;
    assign arm_req   = wr_en && (wr_idx == A_CTRL) && axi_wdata[0];
    assign abort_req = wr_en && (wr_idx == A_CTRL) && axi_wdata[1];

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            trig_mask  <= '0;
            trig_value <= '0;
            edge_mask  <= '0;
            post_count <= '0;
        end else if (wr_en) begin
            case (wr_idx)
                A_MASK:  trig_mask  <= axi_wdata[23:0];
                A_VALUE: trig_value <= axi_wdata[23:0];
                A_EDGE:  edge_mask  <= axi_wdata[23:0];
                A_POST:  post_count <= axi_wdata[15:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage p1: sample user signals; stage p2: previous sample / output
    // ------------------------------------------------------------------
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            data_p1 <= '0;
            data_p2 <= '0;
        end else begin
            data_p1 <= up_la_data;
            data_p2 <= data_p1;
        end
    end

    assign la_data_o = data_p2;

    // Match is evaluated on the p1 sample so the FSM enters CAPTURE on the
    // same edge that moves that sample to la_data_o.
    assign pattern_hit = ((data_p1 & trig_mask) == (trig_value & trig_mask));
    assign edge_hit    = (edge_mask == '0) || (|(edge_mask & (data_p1 ^ data_p2)));
    assign match       = pattern_hit && edge_hit;

    // ------------------------------------------------------------------
    // Trigger FSM
    // ------------------------------------------------------------------
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        arm_take = 1'b0;
        if (abort_req) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_req) begin
                        state_d  = ST_ARMED;
                        arm_take = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (match) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // post_count == 0 keeps the window open until abort.
                    if ((post_count != 16'd0) && (pc_cnt == 16'd1)) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign trig_fire  = (state_q == ST_ARMED) && (state_d == ST_CAPTURE);
    assign cap_end    = (state_q == ST_CAPTURE) && (state_d == ST_DONE);
    assign la_run     = (state_q == ST_CAPTURE);
    assign state_bits = state_q;

    // Window counter: loaded with post_count on trigger so the triggering
    // cycle is the first of post_count window cycles. Held at zero rather
    // than wrapping.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            pc_cnt <= '0;
        end else if (trig_fire) begin
            pc_cnt <= post_count;
        end else if ((state_q == ST_CAPTURE) && (post_count != 16'd0) && (pc_cnt != 16'd0)) begin
            pc_cnt <= pc_cnt - 16'd1;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            trig_seen    <= 1'b0;
            la_trig_done <= 1'b0;
        end else begin
            la_trig_done <= cap_end;
            if (trig_fire) begin
                trig_seen <= 1'b1;
            end else if (arm_take) begin
                trig_seen <= 1'b0;
            end
        end
    end

`ifdef LA_TRIG_TIMESTAMP_EN
    // ------------------------------------------------------------------
    // Arm-to-trigger timestamp
    // ------------------------------------------------------------------
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    logic [31:0] trig_ts;

    // Counts only cycles that stay in ARMED, so the value freezes on the
    // trigger edge and holds through abort.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            trig_ts <= '0;
        end else if (arm_take) begin
            trig_ts <= '0;
        end else if ((state_q == ST_ARMED) && (state_d == ST_ARMED)) begin
            trig_ts <= sat_inc32(trig_ts);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '1;
        case (rd_idx)
            A_MASK:   rd_data = {{(pDATA_WIDTH-24){1'b0}}, trig_mask};
            A_VALUE:  rd_data = {{(pDATA_WIDTH-24){1'b0}}, trig_value};
            A_EDGE:   rd_data = {{(pDATA_WIDTH-24){1'b0}}, edge_mask};
            A_POST:   rd_data = {{(pDATA_WIDTH-16){1'b0}}, post_count};
            A_CTRL:   rd_data = '0;
            A_STATUS: rd_data = {{(pDATA_WIDTH-3){1'b0}}, trig_seen, state_bits};
`ifdef LA_TRIG_TIMESTAMP_EN
            A_TS:     rd_data = pDATA_WIDTH'(trig_ts);
`else
            A_TS:     rd_data = '1;
`endif
            default:  rd_data = '1;
        endcase
    end

    assign axi_rdata = rd_data;

endmodule

// File: tb/tb_la_trigger_unit.sv
// -----------------------------------------------------------------------------
// Testbench for la_trigger_unit: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a cycle-level
// behavioural model of the trigger unit kept in this file.
// -----------------------------------------------------------------------------
module tb_la_trigger_unit;

    logic        axi_clk = 1'b0;
    logic        axi_reset_n = 1'b0;
    logic        axi_awvalid = 1'b0;
    logic [14:0] axi_awaddr = '0;
    logic        axi_wvalid = 1'b0;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = 4'hF;
    logic        axi_awready;
    logic        axi_wready;
    logic        axi_arvalid = 1'b0;
    logic [14:0] axi_araddr = '0;
    logic        axi_rready = 1'b1;
    logic        axi_arready;
    logic        axi_rvalid;
    logic [31:0] axi_rdata;
    logic        cc_la_enable = 1'b1;
    logic [23:0] up_la_data = '0;
    logic [23:0] la_data_o;
    logic        la_run;
    logic        la_trig_done;

    always #5 axi_clk = ~axi_clk;

    la_trigger_unit dut (
        .axi_clk      (axi_clk),
        .axi_reset_n  (axi_reset_n),
        .axi_awvalid  (axi_awvalid),
        .axi_awaddr   (axi_awaddr),
        .axi_wvalid   (axi_wvalid),
        .axi_wdata    (axi_wdata),
        .axi_wstrb    (axi_wstrb),
        .axi_awready  (axi_awready),
        .axi_wready   (axi_wready),
        .axi_arvalid  (axi_arvalid),
        .axi_araddr   (axi_araddr),
        .axi_rready   (axi_rready),
        .axi_arready  (axi_arready),
        .axi_rvalid   (axi_rvalid),
        .axi_rdata    (axi_rdata),
        .cc_la_enable (cc_la_enable),
        .up_la_data   (up_la_data),
        .la_data_o    (la_data_o),
        .la_run       (la_run),
        .la_trig_done (la_trig_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Holds what the unit must look like in the current
    // cycle; advanced once per cycle using that cycle's inputs.
    //   phase: 0 idle, 1 armed, 2 capturing, 3 done (status encoding)
    //   left : capture cycles still owed in a bounded window
    // ------------------------------------------------------------------
    logic [23:0] m_mask = '0, m_value = '0, m_emask = '0;
    logic [15:0] m_post = '0;
    int          m_phase = 0;
    int          m_left = 0;
    bit          m_seen = 1'b0;
    bit          m_done = 1'b0;
    logic [23:0] m_last = '0;     // sample taken one edge ago
    logic [23:0] m_prev = '0;     // sample taken two edges ago (shown on la_data_o)
    logic [31:0] m_ts = '0;

    task automatic m_reset();
        m_mask = '0; m_value = '0; m_emask = '0; m_post = '0;
        m_phase = 0; m_left = 0; m_seen = 1'b0; m_done = 1'b0;
        m_last = '0; m_prev = '0; m_ts = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [14:0] a);
        case (int'(a[11:2]))
            0: return {8'h0, m_mask};
            1: return {8'h0, m_value};
            2: return {8'h0, m_emask};
            3: return {16'h0, m_post};
            4: return 32'h0;
            5: return {29'h0, m_seen, 2'(m_phase)};
`ifdef LA_TRIG_TIMESTAMP_EN
            6: return m_ts;
`endif
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic m_step();
        bit wr, arm, abort, hit;
        int idx;
        wr    = cc_la_enable && axi_awvalid && axi_wvalid;
        idx   = int'(axi_awaddr[11:2]);
        arm   = wr && (idx == 4) && axi_wdata[0];
        abort = wr && (idx == 4) && axi_wdata[1];
        hit   = ((m_last & m_mask) == (m_value & m_mask)) &&
                ((m_emask == 0) || ((m_emask & (m_last ^ m_prev)) != 0));
        m_done = 1'b0;
        if (abort) begin
            m_phase = 0;
        end else if (m_phase == 0 || m_phase == 3) begin
            if (arm) begin
                m_phase = 1; m_seen = 1'b0; m_ts = 0;
            end
        end else if (m_phase == 1) begin
            if (hit) begin
                m_phase = 2; m_left = int'(m_post); m_seen = 1'b1;
            end else if (m_ts != 32'hFFFF_FFFF) begin
                m_ts = m_ts + 1;
            end
        end else begin
            // bounded window: the trigger cycle is the first of m_post cycles
            if (m_post != 0 && m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_phase = 3; m_done = 1'b1;
                end
            end
        end
        m_prev = m_last;
        m_last = up_la_data;
        if (wr) begin
            case (idx)
                0: m_mask  = axi_wdata[23:0];
                1: m_value = axi_wdata[23:0];
                2: m_emask = axi_wdata[23:0];
                3: m_post  = axi_wdata[15:0];
                default: ;
            endcase
        end
    endtask

    // Compare process: outputs checked at every falling edge.
    always @(negedge axi_clk) begin
        if (!axi_reset_n) begin
            m_reset();
            check("rst_la_run", 32'(la_run), 32'd0);
            check("rst_la_data_o", 32'(la_data_o), 32'd0);
            check("rst_la_trig_done", 32'(la_trig_done), 32'd0);
        end else begin
            check("la_run", 32'(la_run), 32'(m_phase == 2));
            check("la_data_o", 32'(la_data_o), 32'(m_prev));
            check("la_trig_done", 32'(la_trig_done), 32'(m_done));
            check("awready_wready", {30'h0, axi_awready, axi_wready},
                  {30'h0, {2{axi_awvalid & axi_wvalid}}});
            m_step();
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic wr(input logic [14:0] a, input logic [31:0] d);
        axi_awaddr  = a;
        axi_wdata   = d;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [14:0] a, input logic [31:0] exp);
        axi_araddr  = a;
        axi_arvalid = 1'b1;
        #2;
        check(name, axi_rdata, exp);
        check("arready_rvalid", {30'h0, axi_arready, axi_rvalid}, 32'h3);
        axi_arvalid = 1'b0;
        tick();
    endtask

    int          w_runs;
    int          w_dones;
    logic [23:0] w_first;

    task automatic watch(input int n);
        w_runs = 0; w_dones = 0; w_first = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (la_run) begin
                if (w_runs == 0) w_first = la_data_o;
                w_runs++;
            end
            if (la_trig_done) w_dones++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [14:0] ra;
        int          sel;

        repeat (3) tick();
        axi_reset_n = 1'b1;
        tick();
        rd_chk("reset_status", 15'h14, 32'h0);
        rd_chk("reset_mask", 15'h00, 32'h0);

        // Pattern trigger
        wr(15'h00, 32'h0000FF);
        wr(15'h04, 32'h000042);
        wr(15'h0C, 32'd4);
        wr(15'h10, 32'h1);
        up_la_data = 24'h000042;
        tick();
        up_la_data = 24'h0;
        watch(12);
        check("pattern_run_len", w_runs, 4);
        check("pattern_first_data", 32'(w_first), 32'h42);
        check("pattern_done_pulses", w_dones, 1);
        rd_chk("pattern_status", 15'h14, 32'h7);

        // Edge trigger
        wr(15'h00, 32'h0);
        wr(15'h08, 32'h1);
        wr(15'h0C, 32'd2);
        wr(15'h10, 32'h1);
        watch(10);
        check("edge_static_zero", w_runs, 0);
        rd_chk("edge_armed_status", 15'h14, 32'h1);
        up_la_data = 24'h000001;
        tick();
        watch(8);
        check("edge_run_len", w_runs, 2);
        check("edge_first_bit0", 32'(w_first[0]), 32'd1);
        check("edge_done_pulses", w_dones, 1);
        wr(15'h10, 32'h1);
        watch(10);
        check("edge_static_one", w_runs, 0);

        // Unbounded capture and abort
        wr(15'h10, 32'h2);
        wr(15'h0C, 32'd0);
        wr(15'h08, 32'h0);
        wr(15'h10, 32'h1);
        watch(1000);
        check("unbounded_run_len", w_runs, 1000);
        wr(15'h10, 32'h2);
        check("abort_drops_run", 32'(la_run), 32'd0);
        rd_chk("abort_status", 15'h14, 32'h4);

        // Abort priority
        wr(15'h10, 32'h3);
        rd_chk("arm_abort_status", 15'h14, 32'h4);
        wr(15'h00, 32'hFF);
        wr(15'h04, 32'h55);
        wr(15'h0C, 32'd3);
        up_la_data = 24'h0;
        wr(15'h10, 32'h1);
        up_la_data = 24'h000055;
        tick();
        up_la_data = 24'h0;
        wr(15'h10, 32'h2);
        watch(6);
        check("match_abort_no_run", w_runs, 0);
        rd_chk("match_abort_status", 15'h14, 32'h0);

        // Register access
        rd_chk("unmapped_1c", 15'h1C, 32'hFFFF_FFFF);
        rd_chk("ctrl_reads_zero", 15'h10, 32'h0);
        cc_la_enable = 1'b0;
        wr(15'h00, 32'hABCDEF);
        cc_la_enable = 1'b1;
        rd_chk("disabled_write_dropped", 15'h00, 32'hFF);

        // Timestamp: match 100 cycles after arm
        wr(15'h04, 32'h77);
        wr(15'h0C, 32'd1);
        up_la_data = 24'h0;
        wr(15'h10, 32'h1);
        repeat (99) tick();
        up_la_data = 24'h000077;
        tick();
        up_la_data = 24'h0;
        watch(4);
        check("ts_run_len", w_runs, 1);
        check("ts_done_pulses", w_dones, 1);
`ifdef LA_TRIG_TIMESTAMP_EN
        rd_chk("timestamp", 15'h18, 32'd100);
`else
        rd_chk("timestamp_absent", 15'h18, 32'hFFFF_FFFF);
`endif

        // Randomized phase
        for (int it = 0; it < 3000; it++) begin
            up_la_data   = 24'($urandom & $urandom);
            cc_la_enable = ($urandom_range(0, 7) != 0);
            axi_wstrb    = 4'($urandom);
            sel          = int'($urandom_range(0, 19));
            case (sel)
                0, 1, 2: wr(15'h10, 32'h1);
                3:       wr(15'h10, 32'h2);
                4:       wr(15'h10, 32'($urandom_range(0, 3)));
                5:       wr(15'h00, $urandom & $urandom & $urandom);
                6:       wr(15'h04, $urandom & $urandom);
                7:       wr(15'h08, $urandom & $urandom & $urandom);
                8:       wr(15'h0C, 32'($urandom_range(0, 6)));
                9:       wr(15'($urandom_range(0, 10) << 2), $urandom);
                10, 11: begin
                    ra = {3'($urandom), 10'($urandom_range(0, 9)), 2'($urandom)};
                    rd_chk("rand_read", ra, m_read(ra));
                end
                12: begin
                    axi_awaddr  = 15'h0;
                    axi_wdata   = $urandom;
                    axi_awvalid = 1'b1;
                    axi_wvalid  = 1'b0;
                    tick();
                    axi_awvalid = 1'b0;
                end
                default: tick();
            endcase
        end
        cc_la_enable = 1'b1;

        // Reset in the middle of a capture
        wr(15'h10, 32'h2);
        wr(15'h00, 32'h0);
        wr(15'h08, 32'h0);
        wr(15'h0C, 32'd0);
        wr(15'h10, 32'h1);
        tick();
        tick();
        check("run_before_reset", 32'(la_run), 32'd1);
        #2;
        axi_reset_n = 1'b0;
        #1;
        check("run_async_reset", 32'(la_run), 32'd0);
        check("data_async_reset", 32'(la_data_o), 32'd0);
        tick();
        rd_chk("reset_mask2", 15'h00, 32'h0);
        rd_chk("reset_value2", 15'h04, 32'h0);
        rd_chk("reset_edge2", 15'h08, 32'h0);
        rd_chk("reset_post2", 15'h0C, 32'h0);
        rd_chk("reset_status2", 15'h14, 32'h0);
`ifdef LA_TRIG_TIMESTAMP_EN
        rd_chk("reset_ts", 15'h18, 32'h0);
`endif
        axi_reset_n = 1'b1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
